// File: rtl/bus_arb2.sv
// bus_arb2: two-master arbiter in front of a single-port register slave.
// Serialises master A/B accesses, holds the slave address for RD_LAT
// cycles, and returns read data with a one-cycle ack to the winner.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_a_* / i_b_*         master request, we, addr, write data
//   o_a_ack, o_a_rdata    master A completion pulse and read data
//   o_b_ack, o_b_rdata    master B completion pulse and read data
//   o_we, o_addr, o_data  slave write enable, address, write data
//   i_rdata               slave registered read data
//   o_busy                access in ISSUE or WAIT
// Build option: define BUS_ARB2_FIXED_PRIO_EN for fixed A-over-B
// priority; round-robin arbitration otherwise.
module bus_arb2 #(
   parameter int DATAW  = 8,
   parameter int ADDRW  = 8,
   parameter int RD_LAT = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_a_req,
   input  logic             i_a_we,
   input  logic [ADDRW-1:0] i_a_addr,
   input  logic [DATAW-1:0] i_a_data,
   output logic             o_a_ack,
   output logic [DATAW-1:0] o_a_rdata,
   input  logic             i_b_req,
   input  logic             i_b_we,
   input  logic [ADDRW-1:0] i_b_addr,
   input  logic [DATAW-1:0] i_b_data,
   output logic             o_b_ack,
   output logic [DATAW-1:0] o_b_rdata,
   output logic             o_we,
   output logic [ADDRW-1:0] o_addr,
   output logic [DATAW-1:0] o_data,
   input  logic [DATAW-1:0] i_rdata,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

   state_t           state_q, state_d;
   logic             gnt_q, gnt_d;
   logic             we_q, we_d;
   logic [ADDRW-1:0] addr_q, addr_d;
   logic [DATAW-1:0] data_q, data_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             a_ack_q, a_ack_d;
   logic             b_ack_q, b_ack_d;
   logic [DATAW-1:0] a_rd_q, a_rd_d;
   logic [DATAW-1:0] b_rd_q, b_rd_d;
   logic             any_req;
   logic             pick_b;

   assign any_req = i_a_req | i_b_req;

`ifdef BUS_ARB2_FIXED_PRIO_EN
   assign pick_b = ~i_a_req;
`else
   // last_q = 1 means B was served last, so A wins the next tie
   logic last_q, last_d;

   assign pick_b = i_b_req & (~i_a_req | ~last_q);

   always_comb begin
      last_d = last_q;
      if (state_q == S_IDLE && any_req)
         last_d = pick_b;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) last_q <= 1'b1;
      else       last_q <= last_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      a_ack_d = 1'b0;
      b_ack_d = 1'b0;
      a_rd_d  = a_rd_q;
      b_rd_d  = b_rd_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               gnt_d   = pick_b;
               we_d    = pick_b ? i_b_we   : i_a_we;
               addr_d  = pick_b ? i_b_addr : i_a_addr;
               data_d  = pick_b ? i_b_data : i_a_data;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               if (gnt_q) begin
                  b_rd_d  = i_rdata;
                  b_ack_d = 1'b1;
               end else begin
                  a_rd_d  = i_rdata;
                  a_ack_d = 1'b1;
               end
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= 4'd0;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         a_rd_q  <= '0;
         b_rd_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         a_ack_q <= a_ack_d;
         b_ack_q <= b_ack_d;
         a_rd_q  <= a_rd_d;
         b_rd_q  <= b_rd_d;
      end
   end

   // address/data registers keep their value outside ISSUE/WAIT
   assign o_we      = (state_q == S_ISSUE) & we_q;
   assign o_addr    = addr_q;
   assign o_data    = data_q;
   assign o_busy    = (state_q == S_ISSUE) | (state_q == S_WAIT);
   assign o_a_ack   = a_ack_q;
   assign o_b_ack   = b_ack_q;
   assign o_a_rdata = a_rd_q;
   assign o_b_rdata = b_rd_q;

endmodule
